// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation codes, controller state encoding and counter sizing.
package mul_div_pkg;

  // RV32M funct3 encodings as seen on the op port
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  // Step counter width for the default operand width
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);

  // Step counter width for an arbitrary operand width
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mul_div_ctrl.sv
// Sequencing for the multiply/divide unit: IDLE/CALC/DONE state machine,
// step counter, and the busy/stall/done handshake towards the pipeline.
module mul_div_ctrl
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic kill,
  output logic stall,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic finish,
  output logic drop
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and step counter registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus the datapath strobes (load operands, run a step,
  // capture the final result, or undo a result killed while in DONE)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d = CALC;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          step = 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            finish  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        drop    = kill;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign stall = !rst && (((state_q == IDLE) && start && !kill) || (state_q == CALC));
  assign done  = !rst && (state_q == DONE) && !kill;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// on issue, a radix-2 shift-add (multiply) or restoring shift-subtract
// (divide) runs one bit per cycle, and the sign is restored as the result
// register is loaded on entry to DONE.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  kill,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;

  logic load, step, finish, drop;

  mul_div_ctrl #(.DATA_WIDTH(W)) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .load   (load),
    .step   (step),
    .finish (finish),
    .drop   (drop)
  );

  op_e          op_q;
  logic [W-1:0] hi_q, lo_q, dsr_q, res_q, prev_q;
  logic         neg_q, rneg_q;

  logic         a_sgn, b_sgn, neg_d;
  logic [W-1:0] a_mag, b_mag;

  // Issue-time operand conditioning: which operands are signed, their
  // magnitudes, and which outputs need negating at the end. A zero divisor
  // leaves the all-ones quotient unnegated.
  always_comb begin
    a_sgn = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM)) && a[W-1];
    b_sgn = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && b[W-1];
    a_mag = a_sgn ? -a : a;
    b_mag = b_sgn ? -b : b;
    neg_d = op[2] ? ((a_sgn ^ b_sgn) && (b != '0)) : (a_sgn ^ b_sgn);
  end

  logic [W:0]     mul_sum, div_sh;
  logic [W-1:0]   div_rem, nxt_hi, nxt_lo;
  logic           div_ok;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, res_d;

  // One iteration step: hi/lo hold product high/multiplier for multiply,
  // or partial remainder/dividend-becoming-quotient for divide
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
    div_sh  = {hi_q, lo_q[W-1]};
    div_ok  = (div_sh >= {1'b0, dsr_q});
    div_rem = div_sh[W-1:0] - dsr_q;
    if (op_q[2]) begin
      nxt_hi = div_ok ? div_rem : div_sh[W-1:0];
      nxt_lo = {lo_q[W-2:0], div_ok};
    end else begin
      nxt_hi = mul_sum[W:1];
      nxt_lo = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  // Sign fix-up of the final step's values and selection of the result
  always_comb begin
    prod     = {nxt_hi, nxt_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -nxt_lo : nxt_lo;
    rem_fix  = rneg_q ? -nxt_hi : nxt_hi;
    case (op_q)
      OP_MUL:                         res_d = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   res_d = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:                res_d = quo_fix;
      OP_REM, OP_REMU:                res_d = rem_fix;
      default:                        res_d = '0;
    endcase
  end

  // Operand/accumulator and result registers; the previous result is kept
  // so a kill during DONE can put it back
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      dsr_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      res_q  <= '0;
      prev_q <= '0;
    end else begin
      if (load) begin
        op_q   <= op_e'(op);
        hi_q   <= '0;
        lo_q   <= a_mag;
        dsr_q  <= b_mag;
        neg_q  <= neg_d;
        rneg_q <= a_sgn;
      end else if (step) begin
        hi_q <= nxt_hi;
        lo_q <= nxt_lo;
      end
      if (finish) begin
        res_q  <= res_d;
        prev_q <= res_q;
      end else if (drop) begin
        res_q <= prev_q;
      end
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at DATA_WIDTH = 32.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, kill;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         stall, busy, done;
  logic [W-1:0] result;

  int           errors = 0;
  int           checks = 0;
  int           done_count = 0;
  logic [W-1:0] last_result = '0;

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Count every done pulse seen at a rising edge
  always @(posedge clk) begin
    if (done === 1'b1) done_count++;
  end

  // Safety net against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Issue one operation in the current IDLE cycle, time it, check the
  // result, and return in the IDLE cycle that follows DONE
  task automatic applyStimulus(input string tag, input logic [2:0] o,
                               input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [W-1:0] exp);
    int cycles;
    int stall_cycles;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1;
    stall_cycles = (stall === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 100) begin
      if (stall === 1'b1) stall_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, ":latency"}, W'(cycles), W'(33));
    checkOutput({tag, ":stall_cycles"}, W'(stall_cycles), W'(33));
    checkOutput({tag, ":stall_in_done"}, W'(stall), W'(0));
    checkOutput(tag, result, exp);
    last_result = exp;
    @(posedge clk); #1;
    checkOutput({tag, ":done_once"}, W'(done), W'(0));
    checkOutput({tag, ":idle"}, W'(busy), W'(0));
  endtask

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset:busy", W'(busy), W'(0));
    checkOutput("reset:done", W'(done), W'(0));
    checkOutput("reset:stall", W'(stall), W'(0));
    checkOutput("reset:result", result, 32'h0);
    rst = 1'b0;

    applyStimulus("mul_7_neg3",      OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB);
    applyStimulus("mulhu_ones",      OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE);
    applyStimulus("mulh_ones",       OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000);
    applyStimulus("mulhsu_neg1_2",   OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF);
    applyStimulus("mulhu_2p31_2",    OP_MULHU,  32'h80000000,   32'd2,        32'h00000001);
    applyStimulus("mul_low",         OP_MUL,    32'h12345678,   32'h10,       32'h23456780);
    applyStimulus("div_m7_2",        OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD);
    applyStimulus("rem_m7_2",        OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF);
    applyStimulus("div_7_m2",        OP_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD);
    applyStimulus("rem_7_m2",        OP_REM,    32'd7,          32'hFFFFFFFE, 32'h00000001);
    applyStimulus("divu_100_0",      OP_DIVU,   32'd100,        32'd0,        32'hFFFFFFFF);
    applyStimulus("remu_100_0",      OP_REMU,   32'd100,        32'd0,        32'd100);
    applyStimulus("div_m5_0",        OP_DIV,    32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF);
    applyStimulus("rem_m5_0",        OP_REM,    32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB);
    applyStimulus("div_overflow",    OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000);
    applyStimulus("rem_overflow",    OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000);
    applyStimulus("divu_big_3",      OP_DIVU,   32'hFFFFFFFF,   32'd3,        32'h55555555);

    // Kill ten cycles into CALC
    n0 = done_count;
    @(negedge clk);
    op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkOutput("kill:busy", W'(busy), W'(0));
    checkOutput("kill:done", W'(done), W'(0));
    checkOutput("kill:result_held", result, last_result);
    checkOutput("kill:no_done_pulse", W'(done_count - n0), W'(0));
    applyStimulus("after_kill_divu", OP_DIVU, 32'd1000, 32'd7, 32'd142);

    // Kill and start together in IDLE: nothing starts
    @(negedge clk);
    op = OP_MUL; a = 32'd2; b = 32'd3; start = 1'b1; kill = 1'b1;
    #1;
    checkOutput("kill_start:stall", W'(stall), W'(0));
    @(posedge clk); #1;
    checkOutput("kill_start:busy", W'(busy), W'(0));
    start = 1'b0; kill = 1'b0;

    // Start held and operands changed while busy: ignored
    n0 = done_count;
    @(negedge clk);
    op = OP_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    op = OP_DIVU; a = 32'd9; b = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("busy_start:done_pulses", W'(done_count - n0), W'(1));
    checkOutput("busy_start:result", result, 32'd15);
    checkOutput("busy_start:idle", W'(busy), W'(0));

    // Reset mid-CALC, with start asserted during reset
    n0 = done_count;
    @(negedge clk);
    op = OP_MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid:busy", W'(busy), W'(0));
    checkOutput("rst_mid:done", W'(done), W'(0));
    checkOutput("rst_mid:stall", W'(stall), W'(0));
    checkOutput("rst_mid:result", result, 32'h0);
    checkOutput("rst_mid:no_done_pulse", W'(done_count - n0), W'(0));
    rst = 1'b0; start = 1'b0;
    applyStimulus("after_rst_mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
